gcd_controller: RTL and testbench

GCD_CONTROLLER -- requirements
Module: gcd_controller

---
 rtl/gcd_controller.sv | 137 +++++++++++++
 tb/tb_gcd_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for a subtract-based GCD datapath
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           begin one computation (sampled in IDLE only)
//   gt, lt, eq      datapath compare flags for A>B, A<B, A==B
//   ldA, ldB        register load enables for A and B
//   sel1, sel2      subtractor operand selects (0 = A, 1 = B)
//   sel_in          bus source (1 = data_in, 0 = subtractor output)
//   busy, done      state decodes: not IDLE / one-cycle completion pulse
//   err             aborted (bad flags or iteration limit), held until next start
//   iter_count      subtract cycles performed, held until next start
module gcd_controller #(
  parameter logic [15:0] MAX_ITER = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        gt,
  input  logic        lt,
  input  logic        eq,
  output logic        ldA,
  output logic        ldB,
  output logic        sel1,
  output logic        sel2,
  output logic        sel_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CALC = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic clr_run;   // accepted start: wipe results of the previous run
  logic iter_inc;  // a subtract load happens this cycle
  logic err_set;   // abort into DONE with an error
  logic flags_onehot;

  assign flags_onehot = ({gt, lt, eq} == 3'b100) ||
                        ({gt, lt, eq} == 3'b010) ||
                        ({gt, lt, eq} == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iter_count <= 16'd0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_run) begin
        iter_count <= 16'd0;
        err        <= 1'b0;
      end else begin
        // Saturating count: the limit check in CALC already stops increments
        // at MAX_ITER, the guard here keeps the counter safe on its own.
        if (iter_inc && (iter_count != MAX_ITER)) begin
          iter_count <= iter_count + 16'd1;
        end
        if (err_set) begin
          err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    clr_run  = 1'b0;
    iter_inc = 1'b0;
    err_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr_run = 1'b1;
          state_d = LDA;
        end
      end
      LDA: begin
        ldA     = 1'b1;
        sel_in  = 1'b1;
        state_d = LDB;
      end
      LDB: begin
        ldB     = 1'b1;
        sel_in  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        // Corrupt flags are checked first so a broken comparator can never
        // be mistaken for a finished or in-progress computation.
        if (!flags_onehot) begin
          err_set = 1'b1;
          state_d = DONE;
        end else if (eq) begin
          state_d = DONE;
        end else if (iter_count == MAX_ITER) begin
          err_set = 1'b1;
          state_d = DONE;
        end else if (gt) begin
          ldA      = 1'b1;
          sel2     = 1'b1;
          iter_inc = 1'b1;
        end else begin
          ldB      = 1'b1;
          sel1     = 1'b1;
          iter_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - directed bench for gcd_controller with a GCD datapath and trace model
module tb_gcd_controller;

  localparam logic [15:0] MAXI = 16'd16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gt, lt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] iter_count;

  logic [15:0] data_in = 16'd0;
  logic [15:0] ra = 16'd0;
  logic [15:0] rb = 16'd0;
  logic [15:0] sub;
  logic        force_both = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0]  outs;     // {ldA, ldB, sel1, sel2, sel_in, busy, done}
    logic        chk_regs;
    logic [15:0] iter;
    logic        err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  gcd_controller #(.MAX_ITER(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gt(gt), .lt(lt), .eq(eq),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  // Simple datapath around the controller.
  assign sub = (sel1 ? rb : ra) - (sel2 ? rb : ra);
  assign gt  = force_both | (ra > rb);
  assign lt  = force_both | (ra < rb);
  assign eq  = !force_both && (ra == rb);

  always @(posedge clk) begin
    if (ldA) ra <= sel_in ? data_in : sub;
    if (ldB) rb <= sel_in ? data_in : sub;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] o, input logic c, input int it, input logic e);
    exp_t x;
    x.outs = o; x.chk_regs = c; x.iter = it[15:0]; x.err = e;
    q.push_back(x);
  endtask

  // Cycle-by-cycle expectation from the subtractive GCD algorithm.
  task automatic build(input int a, input int b, input int fs, output int n, output bit e);
    int x, y, s;
    x = a; y = b; n = 0; e = 0; s = 0;
    push(7'b0000000, 1'b0, 0, 1'b0);           // IDLE with start
    push(7'b1000110, 1'b1, 0, 1'b0);           // load A
    push(7'b0100110, 1'b1, 0, 1'b0);           // load B
    while (1) begin
      if (s == fs) begin
        push(7'b0000010, 1'b1, n, 1'b0); e = 1; break;
      end else if (x == y) begin
        push(7'b0000010, 1'b1, n, 1'b0); break;
      end else if (n == int'(MAXI)) begin
        push(7'b0000010, 1'b1, n, 1'b0); e = 1; break;
      end else if (x > y) begin
        push(7'b1001010, 1'b1, n, 1'b0); x = x - y;
      end else begin
        push(7'b0110010, 1'b1, n, 1'b0); y = y - x;
      end
      n++; s++;
    end
    push(7'b0000011, 1'b1, n, e);              // DONE
    push(7'b0000000, 1'b1, n, e);              // back in IDLE, results held
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("outs[left=%0d]", q.size()),
          {25'd0, ldA, ldB, sel1, sel2, sel_in, busy, done}, {25'd0, e.outs});
      if (e.chk_regs) begin
        chk($sformatf("iter_count[left=%0d]", q.size()), {16'd0, iter_count}, {16'd0, e.iter});
        chk($sformatf("err[left=%0d]", q.size()), {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic run(input int a, input int b, input int fs, input bit hold,
                     input int exp_n, input bit exp_err, input int exp_len);
    int n, len, d, c;
    bit e;
    @(posedge clk); #1;
    build(a, b, fs, n, e);
    len = q.size();
    d = len - 2;
    chk("model_n", n, exp_n);
    chk("model_err", {31'd0, e}, {31'd0, exp_err});
    chk("model_len", len, exp_len);
    start = 1'b1;
    c = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      c++;
      if (c > 400) begin
        chk("timeout", 1, 0);
        q.delete();
        break;
      end
      start      = hold && (c <= d);
      data_in    = (c == 1) ? a[15:0] : ((c == 2) ? b[15:0] : 16'h0bad);
      force_both = (fs >= 0) && (c == 3 + fs);
    end
    start = 1'b0;
    force_both = 1'b0;
    chk("final_iter", {16'd0, iter_count}, exp_n);
    chk("final_err", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    #3;
    chk("reset_outs", {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, 0);
    chk("reset_iter", {16'd0, iter_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(12, 8, -1, 1'b0, 2, 1'b0, 8);     // basic trace
    run(7, 7, -1, 1'b0, 0, 1'b0, 6);      // equal operands
    run(0, 5, -1, 1'b0, 16, 1'b1, 22);    // iteration limit
    run(12, 8, -1, 1'b1, 2, 1'b0, 8);     // start held while busy
    run(12, 8, 1, 1'b0, 1, 1'b1, 7);      // gt and lt forced together

    // Reset in the second CALC cycle.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; data_in = 16'd12;
    @(posedge clk); #1; data_in = 16'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_outs", {ldA, ldB, sel1, sel2, sel_in, busy, done}, 7'b0110010);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, 0);
    chk("mid_reset_iter", {16'd0, iter_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, done}, 0);
    end
    run(9, 6, -1, 1'b0, 2, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
